// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - PLL reset, lock supervision and retry controller
module pll_reset_ctrl #(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 7,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       pll_locked,
  input  logic       force_reset,
  output logic       pll_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_count,
  output logic       lock_lost
);

  localparam logic [2:0] ST_RESET_PLL = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABILIZE = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  localparam int MAX_LEN = (RST_PULSE > LOCK_TIMEOUT)
                         ? ((RST_PULSE > LOCK_STABLE) ? RST_PULSE : LOCK_STABLE)
                         : ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE);

  // Reject parameter sets the counter or retry field cannot represent.
  if (RST_PULSE < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE < 1 ||
      MAX_RETRIES < 0 || MAX_RETRIES > 7 || CNT_W < 1 || CNT_W > 31 ||
      (MAX_LEN - 1) >= (1 << CNT_W)) begin : g_param_check
    $error("pll_reset_ctrl: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       retry_nxt;
  logic             lost_nxt;
  logic             sync_q;
  logic             locked_s;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

  // Cycle counter saturates instead of wrapping.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  // Next-state logic; force_reset overrides every state, lock beats timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    retry_nxt = retry_count;
    lost_nxt  = 1'b0;
    if (force_reset) begin
      state_nxt = ST_RESET_PLL;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = ST_STABILIZE;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_nxt = '0;
            if (retry_count == RETRY_LIMIT) begin
              state_nxt = ST_FAIL;
            end else begin
              state_nxt = ST_RESET_PLL;
              retry_nxt = retry_count + 3'd1;
            end
          end
        end
        ST_STABILIZE: begin
          if (!locked_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
        ST_RUN: begin
          cnt_nxt = cnt;
          if (!locked_s) begin
            state_nxt = ST_RESET_PLL;
            cnt_nxt   = '0;
            retry_nxt = '0;
            lost_nxt  = 1'b1;
          end
        end
        ST_FAIL: begin
          cnt_nxt = cnt;
        end
        default: begin
          state_nxt = ST_RESET_PLL;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= ST_RESET_PLL;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_count <= retry_nxt;
      pll_rst     <= (state_nxt == ST_RESET_PLL);
      ready       <= (state_nxt == ST_RUN);
      fail        <= (state_nxt == ST_FAIL);
      lock_lost   <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb/tb_pll_reset_ctrl.sv - directed self-checking bench for pll_reset_ctrl
module tb_pll_reset_ctrl;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       force_reset = 1'b0;
  logic       pll_rst;
  logic       ready;
  logic       fail;
  logic [2:0] retry_count;
  logic       lock_lost;

  int n_checks = 0;
  int n_errors = 0;
  int edge_i = 0;

  pll_reset_ctrl #(
    .RST_PULSE(4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE(8),
    .MAX_RETRIES(2),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .pll_locked(pll_locked),
    .force_reset(force_reset),
    .pll_rst(pll_rst),
    .ready(ready),
    .fail(fail),
    .retry_count(retry_count),
    .lock_lost(lock_lost)
  );

  // 50 MHz reference clock.
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", tag, edge_i, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later; edge_i is the index of that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_i++;
  endtask

  task automatic run_to(input int e);
    while (edge_i < e) tick();
  endtask

  // After return, the next edge is edge 0 of the sequence.
  task automatic do_reset();
    nrst = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    edge_i = -1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, ".ready"}, 32'(ready), 32'd0);
    chk({tag, ".fail"}, 32'(fail), 32'd0);
    chk({tag, ".retry"}, 32'(retry_count), 32'd0);
    chk({tag, ".lock_lost"}, 32'(lock_lost), 32'd0);
  endtask

  initial begin
    // Lock at edge 10, then lock loss, relock, and force_reset racing lock loss.
    pll_locked = 1'b0;
    do_reset();
    chk_reset_vals("s1_reset");
    run_to(2);  chk("s1_rst_hi", 32'(pll_rst), 32'd1);
    run_to(3);  chk("s1_rst_lo", 32'(pll_rst), 32'd0);
    run_to(9);  pll_locked = 1'b1;
    run_to(19); chk("s1_ready_early", 32'(ready), 32'd0);
    run_to(20); chk("s1_ready", 32'(ready), 32'd1);
    chk("s1_retry", 32'(retry_count), 32'd0);
    chk("s1_fail", 32'(fail), 32'd0);
    chk("s1_pll_rst", 32'(pll_rst), 32'd0);

    run_to(29); pll_locked = 1'b0;
    run_to(31); chk("s4_ready_hold", 32'(ready), 32'd1);
    chk("s4_lost_early", 32'(lock_lost), 32'd0);
    run_to(32); chk("s4_ready_drop", 32'(ready), 32'd0);
    chk("s4_lost_pulse", 32'(lock_lost), 32'd1);
    chk("s4_rst_on", 32'(pll_rst), 32'd1);
    run_to(33); chk("s4_lost_end", 32'(lock_lost), 32'd0);
    run_to(35); chk("s4_rst_last", 32'(pll_rst), 32'd1);
    run_to(36); chk("s4_rst_off", 32'(pll_rst), 32'd0);
    run_to(37); pll_locked = 1'b1;
    run_to(47); chk("s4_relock_early", 32'(ready), 32'd0);
    run_to(48); chk("s4_relock", 32'(ready), 32'd1);

    run_to(49); pll_locked = 1'b0;
    run_to(51); force_reset = 1'b1;
    run_to(52); chk("s6_lost", 32'(lock_lost), 32'd0);
    chk("s6_rst", 32'(pll_rst), 32'd1);
    chk("s6_ready", 32'(ready), 32'd0);
    run_to(53); chk("s6_lost_after", 32'(lock_lost), 32'd0);
    run_to(60); chk("s6_held", 32'(pll_rst), 32'd1);
    force_reset = 1'b0;
    run_to(63); chk("s6_rel_hi", 32'(pll_rst), 32'd1);
    run_to(64); chk("s6_rel_lo", 32'(pll_rst), 32'd0);

    // No lock at all: two retries, then permanent failure; force_reset recovers.
    pll_locked = 1'b0;
    do_reset();
    run_to(22); chk("s2_rst0", 32'(pll_rst), 32'd0);
    chk("s2_retry0", 32'(retry_count), 32'd0);
    run_to(23); chk("s2_rst1", 32'(pll_rst), 32'd1);
    chk("s2_retry1", 32'(retry_count), 32'd1);
    run_to(27); chk("s2_rst1_off", 32'(pll_rst), 32'd0);
    run_to(47); chk("s2_rst2", 32'(pll_rst), 32'd1);
    chk("s2_retry2", 32'(retry_count), 32'd2);
    run_to(51); chk("s2_rst2_off", 32'(pll_rst), 32'd0);
    run_to(70); chk("s2_fail_early", 32'(fail), 32'd0);
    run_to(71); chk("s2_fail", 32'(fail), 32'd1);
    chk("s2_fail_rst", 32'(pll_rst), 32'd0);
    chk("s2_fail_retry", 32'(retry_count), 32'd2);
    run_to(90); chk("s2_fail_hold", 32'(fail), 32'd1);
    chk("s2_fail_hold_rst", 32'(pll_rst), 32'd0);
    force_reset = 1'b1;
    run_to(91); force_reset = 1'b0;
    chk("s5_fail_clr", 32'(fail), 32'd0);
    chk("s5_retry_clr", 32'(retry_count), 32'd0);
    chk("s5_rst_on", 32'(pll_rst), 32'd1);
    run_to(94); chk("s5_rst_last", 32'(pll_rst), 32'd1);
    run_to(95); chk("s5_rst_off", 32'(pll_rst), 32'd0);

    // Lock drops during STABILIZE: back to WAIT_LOCK with a fresh timeout.
    pll_locked = 1'b0;
    do_reset();
    run_to(9);  pll_locked = 1'b1;
    run_to(14); pll_locked = 1'b0;
    run_to(17); chk("s3_no_ready", 32'(ready), 32'd0);
    run_to(24); chk("s3_old_timeout", 32'(pll_rst), 32'd0);
    run_to(36); chk("s3_before_to", 32'(pll_rst), 32'd0);
    chk("s3_retry_kept", 32'(retry_count), 32'd0);
    chk("s3_ready_never", 32'(ready), 32'd0);
    run_to(37); chk("s3_timeout", 32'(pll_rst), 32'd1);
    chk("s3_retry_inc", 32'(retry_count), 32'd1);

    // nrst asserted mid-STABILIZE clears everything on the next edge.
    pll_locked = 1'b1;
    do_reset();
    run_to(7);  nrst = 1'b0;
    run_to(8);  chk_reset_vals("s5_mid_reset");
    tick();
    nrst = 1'b1;
    edge_i = -1;
    run_to(11); chk("s5_rerun_early", 32'(ready), 32'd0);
    run_to(12); chk("s5_rerun_ready", 32'(ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
Reset/lock supervisor sitting directly upstream of the board PLL wrapper (50 MHz refclk -> 3.3 MHz outclk).
- Runs on the free-running 50 MHz reference clock and drives the PLL's active-high reset.
- Synchronises the PLL's asynchronous locked flag, retries on lock timeout and reports permanent failure.
- Emits a clean ready flag that downstream reset bridges use to release logic in the PLL output domain.

Parameters:
RST_PULSE, 16, cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 50000, cycles waited for lock per attempt (1 ms at 50 MHz, >=1)
LOCK_STABLE, 1024, consecutive synchronised-locked cycles required before ready (>=1)
MAX_RETRIES, 7, extra attempts after the first before declaring failure (0..7)
CNT_W, 16, width of the shared cycle counter; must hold max(RST_PULSE, LOCK_TIMEOUT, LOCK_STABLE)-1

Ports:
clk  in  1  50 MHz reference clock (same net as PLL refclk)
nrst  in  1  synchronous active-low reset
pll_locked  in  1  PLL locked flag, asynchronous to clk
force_reset  in  1  synchronous request to restart the lock sequence
pll_rst  out  1  active-high reset to the PLL
ready  out  1  PLL locked and stable
fail  out  1  lock not achieved after MAX_RETRIES+1 attempts
retry_count  out  3  retries consumed in the current sequence
lock_lost  out  1  one-cycle pulse when lock drops while ready

Behaviour:
Clock and reset
- Single clock domain clk; reset is synchronous and active-low on nrst.
- nrst=0 at an edge gives: state RESET_PLL, cnt=0, sync flops=0, pll_rst=1, ready=0, fail=0, retry_count=0, lock_lost=0.
- Reset mid-operation behaves identically: no state is retained.

Synchronisation
- pll_locked passes through 2 flops to give locked_s.
- locked_s is 1 at the edge after the first sampling edge.

Outputs
- All outputs are registered and are a pure function of the registered state:
  - pll_rst=1 iff RESET_PLL
  - ready=1 iff RUN
  - fail=1 iff FAIL

State machine (cnt clears on every state change)
- RESET_PLL: stays exactly RST_PULSE cycles (cnt 0..RST_PULSE-1), then goes to WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1 -> STABILIZE.
  - Otherwise cnt increments. At cnt==LOCK_TIMEOUT-1 without lock (exactly LOCK_TIMEOUT cycles):
    - retry_count==MAX_RETRIES -> FAIL
    - else retry_count+1 -> RESET_PLL
- STABILIZE:
  - locked_s=0 -> WAIT_LOCK; retry_count unchanged and the timeout restarts.
  - At cnt==LOCK_STABLE-1 with locked_s=1 -> RUN.
  - First RUN cycle = sampling edge index LOCK_STABLE+2, counting the first edge sampling pll_locked=1 as 0.
- RUN:
  - Holds while locked_s=1; retry_count holds its value.
  - locked_s=0 -> RESET_PLL, lock_lost=1 for exactly that one cycle, retry_count cleared.
- FAIL: pll_rst=0, fail=1. Stays until nrst or force_reset.

force_reset
- Highest priority after nrst, in any state: go to RESET_PLL, cnt=0, retry_count=0, no lock_lost pulse.
- Held high, it keeps the block in RESET_PLL (pll_rst=1) indefinitely.

Simultaneous events
- force_reset together with lock loss in RUN: force_reset wins, lock_lost=0.
- Timeout together with locked_s rising on the same edge: lock wins -> STABILIZE.

Counter
- cnt saturates, never wraps. Parameter legality is checked by elaboration assertion.

Test Plan:
Params for all scenarios: RST_PULSE=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2. Cycle 0 = first edge after nrst release.
1. pll_locked driven high at cycle 10 -> pll_rst=1 cycles 0-3 only; ready rises at edge 20; retry_count=0, fail=0.
2. pll_locked held 0 -> pll_rst high cycles 0-3, 24-27, 48-51; retry_count 1 at 24, 2 at 48; fail=1 from cycle 72 with pll_rst=0 thereafter.
3. pll_locked high 5 cycles then low during STABILIZE -> ready never asserts, state returns to WAIT_LOCK with a fresh 20-cycle timeout, retry_count unchanged, no pll_rst pulse.
4. Reach RUN, then drop pll_locked -> 2 cycles later ready=0 and lock_lost=1 for one cycle; pll_rst high 4 cycles; re-lock gives ready again after LOCK_STABLE+2 edges.
5. In FAIL, assert force_reset one cycle -> fail=0, retry_count=0, pll_rst high 4 cycles. Separately, nrst=0 mid-STABILIZE -> all outputs at reset values on the next edge.
6. force_reset and lock loss asserted on the same edge in RUN -> lock_lost stays 0, pll_rst=1 next cycle.
